// File: rtl/console_pkg.sv
// Shared state encoding, control-code values and default geometry for the text console.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } console_state_t;

  localparam logic [7:0] CH_BS  = 8'd8;
  localparam logic [7:0] CH_LF  = 8'd10;
  localparam logic [7:0] CH_FF  = 8'd12;
  localparam logic [7:0] CH_CR  = 8'd13;
  localparam logic [7:0] CH_SP  = 8'd32;
  localparam logic [7:0] CH_DEL = 8'd127;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;
  localparam int DEF_FILL = 32;

endpackage

// File: rtl/text_console.sv
// Byte-stream console: cursor tracking, one cell write per cycle, write visible the cycle after accept.
// in_ready is high only when no clear sweep runs; printables stream every cycle until a row advance.
module text_console
  import console_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int FILL_CHR = DEF_FILL
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] char_x,
  output logic [5:0] char_y,
  output logic [8:0] char_chr,
  output logic       char_str,
  output logic [6:0] cur_x,
  output logic [5:0] cur_y,
  output logic       busy
);

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [5:0] LAST_Y = 6'(ROWS - 1);
  localparam logic [8:0] FILL   = 9'(FILL_CHR);

  console_state_t state;
  logic [6:0]     sx;
  logic [5:0]     sy;
  logic           sweep_end;
  logic [5:0]     next_y;
  logic           printable;

  assign next_y    = (cur_y == LAST_Y) ? 6'd0 : cur_y + 6'd1;
  assign printable = (in_data >= CH_SP) && (in_data < CH_DEL);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state     <= CLR_ALL;
      cur_x     <= '0;
      cur_y     <= '0;
      sx        <= '0;
      sy        <= '0;
      sweep_end <= 1'b0;
      char_x    <= '0;
      char_y    <= '0;
      char_chr  <= '0;
      char_str  <= 1'b0;
    end else begin
      char_str <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (printable) begin
              char_x   <= cur_x;
              char_y   <= cur_y;
              char_chr <= {1'b0, in_data};
              char_str <= 1'b1;
              if (cur_x == LAST_X) begin
                // The row clear starts one cycle later, after this character's write.
                cur_x     <= '0;
                cur_y     <= next_y;
                sx        <= '0;
                sweep_end <= 1'b0;
                state     <= CLR_ROW;
              end else begin
                cur_x <= cur_x + 7'd1;
              end
            end else if (in_data == CH_CR) begin
              cur_x <= '0;
            end else if (in_data == CH_LF) begin
              // The first clear cell is emitted now so the sweep overlaps the accept cycle.
              cur_x     <= '0;
              cur_y     <= next_y;
              char_x    <= '0;
              char_y    <= next_y;
              char_chr  <= FILL;
              char_str  <= 1'b1;
              sx        <= 7'd1;
              sweep_end <= 1'b0;
              state     <= CLR_ROW;
            end else if (in_data == CH_BS) begin
              if (cur_x != '0) begin
                cur_x    <= cur_x - 7'd1;
                char_x   <= cur_x - 7'd1;
                char_y   <= cur_y;
                char_chr <= FILL;
                char_str <= 1'b1;
              end
            end else if (in_data == CH_FF) begin
              cur_x     <= '0;
              cur_y     <= '0;
              char_x    <= '0;
              char_y    <= '0;
              char_chr  <= FILL;
              char_str  <= 1'b1;
              sx        <= 7'd1;
              sy        <= '0;
              sweep_end <= 1'b0;
              state     <= CLR_ALL;
            end
          end
        end

        CLR_ROW: begin
          if (sweep_end) begin
            sweep_end <= 1'b0;
            state     <= IDLE;
          end else begin
            char_x   <= sx;
            char_y   <= cur_y;
            char_chr <= FILL;
            char_str <= 1'b1;
            if (sx == LAST_X) sweep_end <= 1'b1;
            else              sx <= sx + 7'd1;
          end
        end

        CLR_ALL: begin
          if (sweep_end) begin
            sweep_end <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
            state     <= IDLE;
          end else begin
            char_x   <= sx;
            char_y   <= sy;
            char_chr <= FILL;
            char_str <= 1'b1;
            if (sx == LAST_X) begin
              sx <= '0;
              if (sy == LAST_Y) sweep_end <= 1'b1;
              else              sy <= sy + 6'd1;
            end else begin
              sx <= sx + 7'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
